// File: rtl/beep_pkg.sv
// Shared types for the buzzer pattern sequencer: FSM states, pattern modes,
// and the per-segment tone selection.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ALT = 2'd0;
  localparam logic [1:0] MODE_A   = 2'd1;
  localparam logic [1:0] MODE_B   = 2'd2;
  localparam logic [1:0] MODE_GAP = 2'd3;

  typedef enum logic [1:0] {
    TONE_A   = 2'd0,
    TONE_B   = 2'd1,
    TONE_OFF = 2'd2
  } tone_e;

  // Tone carried by a segment, given the latched mode and segment parity.
  function automatic tone_e seg_tone(input logic [1:0] mode, input logic odd);
    tone_e t;
    t = TONE_A;
    case (mode)
      MODE_ALT: t = odd ? TONE_B : TONE_A;
      MODE_A:   t = TONE_A;
      MODE_B:   t = TONE_B;
      MODE_GAP: t = odd ? TONE_OFF : TONE_A;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Half-period square-wave divider: tone toggles every `half` enabled cycles;
// clr forces phase back to zero with the tone low.
module tone_div #(
  parameter int unsigned DIV_W  = 1,
  parameter int unsigned HALF_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              tone
);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tone_q, tone_d;
  logic [HALF_W-1:0] half_m1;

  assign half_m1 = half - HALF_W'(1);

  always_comb begin
    div_d  = div_q;
    tone_d = tone_q;
    if (clr) begin
      div_d  = '0;
      tone_d = 1'b0;
    end else if (en) begin
      if (HALF_W'(div_q) == half_m1) begin
        div_d  = '0;
        tone_d = ~tone_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/beep_seq.sv
// Tone-pattern sequencer for the game buzzer: plays NUM_SEG segments of
// SEG_TICKS cycles, each carrying tone A, tone B or silence per the latched mode.
module beep_seq
  import beep_pkg::*;
#(
  parameter int unsigned SEG_TICKS = 250,
  parameter int unsigned NUM_SEG   = 4,
  parameter int unsigned HALF_A    = 1,
  parameter int unsigned HALF_B    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode,
  output logic       beep,
  output logic       busy,
  output logic       over
);

  localparam int unsigned TICK_W   = (SEG_TICKS > 1) ? $clog2(SEG_TICKS) : 1;
  localparam int unsigned SEG_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int unsigned HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned DIV_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              busy_q, busy_d;
  logic              over_q, over_d;
  logic              seg_end;
  logic              adv;
  logic              tone_en;
  tone_e             sel;
  logic [HALF_W-1:0] half;

  assign seg_end = (tick_q == TICK_W'(SEG_TICKS - 1));
  assign sel     = seg_tone(mode_q, seg_q[0]);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    seg_d   = seg_q;
    adv     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PLAY;
          mode_d  = mode;
          tick_d  = '0;
          seg_d   = '0;
        end
      end
      PLAY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (seg_end) begin
          tick_d = '0;
          if (seg_q == SEG_W'(NUM_SEG - 1)) state_d = DONE;
          else seg_d = seg_q + SEG_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
          adv    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PLAY);
    over_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ALT;
      tick_q  <= '0;
      seg_q   <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
    end
  end

  // Divider only runs while staying inside an audible segment; every other
  // transition (entry, segment boundary, exit) re-phases it to zero.
  assign tone_en = adv && (sel != TONE_OFF);
  assign half    = (sel == TONE_B) ? HALF_W'(HALF_B) : HALF_W'(HALF_A);

  tone_div #(
    .DIV_W (DIV_W),
    .HALF_W(HALF_W)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (~adv),
    .en  (tone_en),
    .half(half),
    .tone(beep)
  );

  assign busy = busy_q;
  assign over = over_q;

endmodule
